// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   Resolves one of eight compare modes on two operands and computes the
//   branch target br_pc + br_offset. A taken branch is registered into a
//   one-cycle REDIRECT (pc_sel high). A counted FLUSH phase follows, and
//   squashes wrong-path instructions until FLUSH_DEPTH flush cycles have elapsed.
//   Optional feature macro: BRANCH_STATS_EN. It adds saturating counters for
//   resolved and taken branches. Without it, br_count and taken_count read 0.
module branch_resolve_unit #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              br_valid,
    input  logic [2:0]        br_op,
    input  logic [DATA_W-1:0] rs_a,
    input  logic [DATA_W-1:0] rs_b,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [ADDR_W-1:0] br_offset,
    input  logic              stall,
    output logic              pc_sel,
    output logic [ADDR_W-1:0] pc_target,
    output logic              flush,
    output logic              busy,
    output logic [CNT_W-1:0]  br_count,
    output logic [CNT_W-1:0]  taken_count
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    // Counter only needs to hold FLUSH_DEPTH-1 (at least one bit).
    localparam int FC_W = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_DEPTH - 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(1);

    state_t            state_r, state_s;
    logic [FC_W-1:0]   fcnt_r, fcnt_s;
    logic              pc_sel_r, flush_r, busy_r;
    logic [ADDR_W-1:0] pc_target_r;
    logic              accept_s, taken_s;
    logic [ADDR_W-1:0] target_s;

    // Branch condition for a given compare mode.
    function automatic logic eval_cond(input logic [2:0]        op,
                                       input logic [DATA_W-1:0] a,
                                       input logic [DATA_W-1:0] b);
        logic res;
        case (op)
            3'b000:  res = 1'b0;
            3'b001:  res = (a == b);
            3'b010:  res = (a != b);
            3'b011:  res = ($signed(a) <  $signed(b));
            3'b100:  res = ($signed(a) >= $signed(b));
            3'b101:  res = (a <  b);
            3'b110:  res = (a >= b);
            3'b111:  res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // Accept, condition and target are evaluated only in the accept cycle.
    assign accept_s = br_valid && !stall && (state_r == ST_IDLE);
    assign taken_s  = accept_s && eval_cond(br_op, rs_a, rs_b);
    assign target_s = br_pc + br_offset;

    // Next-state and flush-counter logic.
    always_comb begin
        state_s = state_r;
        fcnt_s  = fcnt_r;
        case (state_r)
            ST_IDLE: begin
                if (taken_s) begin
                    state_s = ST_REDIRECT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REDIRECT: begin
                if (!stall) begin
                    if (FLUSH_DEPTH > 1) begin
                        state_s = ST_FLUSH;
                        fcnt_s  = FC_LOAD;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_REDIRECT;
                end
            end
            ST_FLUSH: begin
                if (!stall) begin
                    if (fcnt_r == FC_LAST) begin
                        state_s = ST_IDLE;
                    end else begin
                        fcnt_s = fcnt_r - FC_LAST;
                    end
                end else begin
                    state_s = ST_FLUSH;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counter and registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            fcnt_r      <= {FC_W{1'b0}};
            pc_sel_r    <= 1'b0;
            flush_r     <= 1'b0;
            busy_r      <= 1'b0;
            pc_target_r <= {ADDR_W{1'b0}};
        end else begin
            state_r  <= state_s;
            fcnt_r   <= fcnt_s;
            pc_sel_r <= (state_s == ST_REDIRECT);
            flush_r  <= (state_s != ST_IDLE);
            busy_r   <= (state_s != ST_IDLE);
            if (taken_s) begin
                pc_target_r <= target_s;
            end
        end
    end

    assign pc_sel    = pc_sel_r;
    assign flush     = flush_r;
    assign busy      = busy_r;
    assign pc_target = pc_target_r;

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] br_cnt_r, taken_cnt_r;

    // Saturating counters of resolved and taken branches.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_r    <= {CNT_W{1'b0}};
            taken_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (accept_s && (br_cnt_r != {CNT_W{1'b1}})) begin
                br_cnt_r <= br_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (taken_s && (taken_cnt_r != {CNT_W{1'b1}})) begin
                taken_cnt_r <= taken_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign br_count    = br_cnt_r;
    assign taken_count = taken_cnt_r;
`else
    assign br_count    = {CNT_W{1'b0}};
    assign taken_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit (FLUSH_DEPTH=2), plus a CNT_W=2 copy
// that shares the same stimulus and exercises counter saturation.
module tb_branch_resolve_unit;

`ifdef BRANCH_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst, br_valid, stall;
    logic [2:0]  br_op;
    logic [31:0] rs_a, rs_b, br_pc, br_offset;
    logic        pc_sel, flush, busy;
    logic [31:0] pc_target;
    logic [15:0] br_count, taken_count;
    logic        s_pc_sel, s_flush, s_busy;
    logic [31:0] s_pc_target;
    logic [1:0]  s_br_count, s_taken_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_br   = 0;
    int exp_tk   = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.DATA_W(32), .ADDR_W(32), .FLUSH_DEPTH(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .br_valid(br_valid), .br_op(br_op), .rs_a(rs_a), .rs_b(rs_b),
        .br_pc(br_pc), .br_offset(br_offset), .stall(stall), .pc_sel(pc_sel),
        .pc_target(pc_target), .flush(flush), .busy(busy),
        .br_count(br_count), .taken_count(taken_count)
    );

    branch_resolve_unit #(.DATA_W(32), .ADDR_W(32), .FLUSH_DEPTH(2), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .br_valid(br_valid), .br_op(br_op), .rs_a(rs_a), .rs_b(rs_b),
        .br_pc(br_pc), .br_offset(br_offset), .stall(stall), .pc_sel(s_pc_sel),
        .pc_target(s_pc_target), .flush(s_flush), .busy(s_busy),
        .br_count(s_br_count), .taken_count(s_taken_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] pc, input logic [31:0] off);
        br_valid  = 1'b1;
        br_op     = op;
        rs_a      = a;
        rs_b      = b;
        br_pc     = pc;
        br_offset = off;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0;
        present(3'b111, 32'd0, 32'd0, 32'h0000_0050, 32'h0000_0004);
        tick(); tick();
        n_checks++;
        if ({pc_sel, flush, busy} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctl: got %b expected %b", {pc_sel, flush, busy}, 3'b000);
        end
        n_checks++;
        if (pc_target !== 32'h0) begin
            n_fail++; $display("FAIL reset_target: got %h expected %h", pc_target, 32'h0);
        end
        n_checks++;
        if ({br_count, taken_count} !== 32'h0) begin
            n_fail++; $display("FAIL reset_counts: got %h expected %h", {br_count, taken_count}, 32'h0);
        end
        rst = 1'b0; br_valid = 1'b0;
        tick();
        n_checks++;
        if ({pc_sel, flush, busy} !== 3'b000) begin
            n_fail++; $display("FAIL reset_release: got %b expected %b", {pc_sel, flush, busy}, 3'b000);
        end
    endtask

    task automatic test_eq_taken();
        present(3'b001, 32'h1234, 32'h1234, 32'h100, 32'h20);
        tick(); br_valid = 1'b0; exp_br++; exp_tk++;
        n_checks++;
        if ({pc_sel, flush, busy} !== 3'b111 || pc_target !== 32'h120) begin
            n_fail++; $display("FAIL eq_redirect: got %b/%h expected 111/00000120", {pc_sel, flush, busy}, pc_target);
        end
        tick();
        n_checks++;
        if ({pc_sel, flush, busy} !== 3'b011) begin
            n_fail++; $display("FAIL eq_flush: got %b expected %b", {pc_sel, flush, busy}, 3'b011);
        end
        tick();
        n_checks++;
        if ({pc_sel, flush, busy} !== 3'b000) begin
            n_fail++; $display("FAIL eq_idle: got %b expected %b", {pc_sel, flush, busy}, 3'b000);
        end
    endtask

    task automatic test_signed_unsigned();
        present(3'b011, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h40);
        tick(); br_valid = 1'b0; exp_br++; exp_tk++;
        n_checks++;
        if ({pc_sel, flush, busy} !== 3'b111 || pc_target !== 32'h240) begin
            n_fail++; $display("FAIL lt_taken: got %b/%h expected 111/00000240", {pc_sel, flush, busy}, pc_target);
        end
        tick(); tick();
        present(3'b101, 32'hFFFF_FFFF, 32'h1, 32'h300, 32'h40);
        tick(); br_valid = 1'b0; exp_br++;
        n_checks++;
        if ({pc_sel, flush, busy} !== 3'b000 || pc_target !== 32'h240) begin
            n_fail++; $display("FAIL ltu_not_taken: got %b/%h expected 000/00000240", {pc_sel, flush, busy}, pc_target);
        end
        tick();
        n_checks++;
        if ({pc_sel, flush, busy} !== 3'b000) begin
            n_fail++; $display("FAIL ltu_quiet: got %b expected %b", {pc_sel, flush, busy}, 3'b000);
        end
    endtask

    task automatic test_stall();
        present(3'b111, 32'h0, 32'h0, 32'h400, 32'h8);
        tick(); br_valid = 1'b0; stall = 1'b1; exp_br++; exp_tk++;
        n_checks++;
        if ({pc_sel, flush, busy} !== 3'b111 || pc_target !== 32'h408) begin
            n_fail++; $display("FAIL stall_accept: got %b/%h expected 111/00000408", {pc_sel, flush, busy}, pc_target);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({pc_sel, flush, busy} !== 3'b111) begin
                n_fail++; $display("FAIL stall_redirect_hold%0d: got %b expected %b", i, {pc_sel, flush, busy}, 3'b111);
            end
        end
        stall = 1'b0;
        tick();
        n_checks++;
        if ({pc_sel, flush, busy} !== 3'b011) begin
            n_fail++; $display("FAIL stall_flush: got %b expected %b", {pc_sel, flush, busy}, 3'b011);
        end
        stall = 1'b1;
        tick();
        n_checks++;
        if ({pc_sel, flush, busy} !== 3'b011) begin
            n_fail++; $display("FAIL stall_flush_hold: got %b expected %b", {pc_sel, flush, busy}, 3'b011);
        end
        stall = 1'b0;
        tick();
        n_checks++;
        if ({pc_sel, flush, busy} !== 3'b000) begin
            n_fail++; $display("FAIL stall_idle: got %b expected %b", {pc_sel, flush, busy}, 3'b000);
        end
        stall = 1'b1;
        present(3'b111, 32'h0, 32'h0, 32'h480, 32'h8);
        tick(); br_valid = 1'b0; stall = 1'b0;
        n_checks++;
        if ({pc_sel, flush, busy} !== 3'b000 || pc_target !== 32'h408) begin
            n_fail++; $display("FAIL stall_blocks_accept: got %b/%h expected 000/00000408", {pc_sel, flush, busy}, pc_target);
        end
    endtask

    task automatic test_wrap_squash();
        present(3'b111, 32'h0, 32'h0, 32'hFFFF_FFF0, 32'h20);
        tick(); exp_br++; exp_tk++;
        n_checks++;
        if ({pc_sel, flush, busy} !== 3'b111 || pc_target !== 32'h10) begin
            n_fail++; $display("FAIL wrap_target: got %b/%h expected 111/00000010", {pc_sel, flush, busy}, pc_target);
        end
        present(3'b111, 32'h0, 32'h0, 32'h500, 32'h0);
        tick();
        n_checks++;
        if ({pc_sel, flush, busy} !== 3'b011 || pc_target !== 32'h10) begin
            n_fail++; $display("FAIL squash_flush: got %b/%h expected 011/00000010", {pc_sel, flush, busy}, pc_target);
        end
        tick();
        n_checks++;
        if ({pc_sel, flush, busy} !== 3'b000 || pc_target !== 32'h10) begin
            n_fail++; $display("FAIL squash_exit: got %b/%h expected 000/00000010", {pc_sel, flush, busy}, pc_target);
        end
        br_valid = 1'b0;
        tick();
        n_checks++;
        if (br_count !== 16'(STATS * exp_br) || taken_count !== 16'(STATS * exp_tk)) begin
            n_fail++; $display("FAIL squash_counts: got %0d/%0d expected %0d/%0d",
                               br_count, taken_count, STATS * exp_br, STATS * exp_tk);
        end
    endtask

    task automatic test_ops();
        logic [31:0] va [3];
        logic [31:0] vb [3];
        logic [7:0]  vm [3];
        logic        exp_t;
        va[0] = 32'd5;          vb[0] = 32'hFFFF_FFFD; vm[0] = 8'b1011_0100;
        va[1] = 32'd7;          vb[1] = 32'd7;         vm[1] = 8'b1101_0010;
        va[2] = 32'hFFFF_FFFF;  vb[2] = 32'd1;         vm[2] = 8'b1100_1100;
        for (int p = 0; p < 3; p++) begin
            for (int op = 0; op < 8; op++) begin
                present(3'(op), va[p], vb[p], 32'h1000 + 32'(op * 16), 32'h4);
                tick(); br_valid = 1'b0; exp_br++;
                exp_t = vm[p][op];
                n_checks++;
                if (pc_sel !== exp_t) begin
                    n_fail++; $display("FAIL op_p%0d_op%0d: pc_sel got %b expected %b", p, op, pc_sel, exp_t);
                end
                if (exp_t) begin
                    exp_tk++;
                    n_checks++;
                    if (pc_target !== 32'h1004 + 32'(op * 16)) begin
                        n_fail++; $display("FAIL op_target_p%0d_op%0d: got %h expected %h",
                                           p, op, pc_target, 32'h1004 + 32'(op * 16));
                    end
                    tick(); tick();
                end
            end
        end
    endtask

    task automatic test_reset_mid_flush();
        present(3'b111, 32'h0, 32'h0, 32'h600, 32'h10);
        tick(); br_valid = 1'b0;
        tick();
        n_checks++;
        if ({pc_sel, flush, busy} !== 3'b011) begin
            n_fail++; $display("FAIL rmf_in_flush: got %b expected %b", {pc_sel, flush, busy}, 3'b011);
        end
        rst = 1'b1;
        present(3'b111, 32'h0, 32'h0, 32'h700, 32'h4);
        tick(); exp_br = 0; exp_tk = 0;
        n_checks++;
        if ({pc_sel, flush, busy} !== 3'b000 || pc_target !== 32'h0) begin
            n_fail++; $display("FAIL rmf_abandon: got %b/%h expected 000/00000000", {pc_sel, flush, busy}, pc_target);
        end
        rst = 1'b0;
        tick(); br_valid = 1'b0; exp_br++; exp_tk++;
        n_checks++;
        if ({pc_sel, flush, busy} !== 3'b111 || pc_target !== 32'h704) begin
            n_fail++; $display("FAIL rmf_new_branch: got %b/%h expected 111/00000704", {pc_sel, flush, busy}, pc_target);
        end
        tick(); tick();
        n_checks++;
        if ({pc_sel, flush, busy} !== 3'b000) begin
            n_fail++; $display("FAIL rmf_drain: got %b expected %b", {pc_sel, flush, busy}, 3'b000);
        end
    endtask

    task automatic test_stats();
        logic [2:0] ops [8];
        ops[0] = 3'b111; ops[1] = 3'b000; ops[2] = 3'b001; ops[3] = 3'b010; ops[4] = 3'b111;
        ops[5] = 3'b111; ops[6] = 3'b111; ops[7] = 3'b111;
        rst = 1'b1; tick(); rst = 1'b0; exp_br = 0; exp_tk = 0;
        for (int i = 0; i < 8; i++) begin
            present(ops[i], 32'h9, 32'h9, 32'h800, 32'h4);
            tick(); br_valid = 1'b0; exp_br++;
            if (pc_sel) begin
                exp_tk++;
                tick(); tick();
            end
            if (i == 4) begin
                n_checks++;
                if (br_count !== 16'(STATS * 5) || taken_count !== 16'(STATS * 3)) begin
                    n_fail++; $display("FAIL stats_5_3: got %0d/%0d expected %0d/%0d",
                                       br_count, taken_count, STATS * 5, STATS * 3);
                end
            end
        end
        n_checks++;
        if (br_count !== 16'(STATS * 8) || taken_count !== 16'(STATS * 6)) begin
            n_fail++; $display("FAIL stats_8_6: got %0d/%0d expected %0d/%0d",
                               br_count, taken_count, STATS * 8, STATS * 6);
        end
        n_checks++;
        if (s_br_count !== 2'(STATS * 3) || s_taken_count !== 2'(STATS * 3)) begin
            n_fail++; $display("FAIL stats_saturate: got %0d/%0d expected %0d/%0d",
                               s_br_count, s_taken_count, STATS * 3, STATS * 3);
        end
    endtask

    initial begin
        rst = 1'b1; br_valid = 1'b0; stall = 1'b0;
        br_op = 3'b000; rs_a = 32'h0; rs_b = 32'h0; br_pc = 32'h0; br_offset = 32'h0;
        test_reset();
        test_eq_taken();
        test_signed_unsigned();
        test_stall();
        test_wrap_squash();
        test_ops();
        test_reset_mid_flush();
        test_stats();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised successor to the single-condition branch gate.
- Evaluates eight compare modes on two DATA_W operands and computes the branch target.
- Registers the redirect to fetch, then drives a counted flush of wrong-path instructions.
- Sits between the execute-stage ALU operands and the PC mux / pipeline-flush logic.

Parameters:
- DATA_W, 32, operand width for comparisons.
- ADDR_W, 32, PC and target width.
- FLUSH_DEPTH, 2, cycles of flush per taken branch; legal range >= 1.
- CNT_W, 16, width of statistics counters (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- br_valid  in  1  branch instruction present in execute.
- br_op  in  3  compare mode; encodings under Behaviour.
- rs_a  in  DATA_W  operand A.
- rs_b  in  DATA_W  operand B.
- br_pc  in  ADDR_W  PC of the branch.
- br_offset  in  ADDR_W  sign-extended offset.
- stall  in  1  pipeline hold; no accept and no state advance while high.
- pc_sel  out  1  select pc_target at the fetch PC mux.
- pc_target  out  ADDR_W  registered redirect address.
- flush  out  1  squash younger pipeline stages.
- busy  out  1  unit is redirecting or flushing.
- br_count  out  CNT_W  branches resolved (BRANCH_STATS_EN only).
- taken_count  out  CNT_W  branches taken (BRANCH_STATS_EN only).

Behaviour:
- Reset (synchronous, active-high):
  - State returns to IDLE.
  - pc_sel, flush and busy are 0; pc_target is 0.
  - Statistics counters are 0.
  - A reset that arrives mid-redirect or mid-flush abandons the operation at the next edge.
- br_op encodings:
  - 000 NEVER; 001 EQ; 010 NE.
  - 011 LT (signed); 100 GE (signed).
  - 101 LTU (unsigned); 110 GEU (unsigned).
  - 111 ALWAYS.
- Target: br_pc + br_offset, truncated modulo 2^ADDR_W. Wrap-around is silent.
- Accept condition: br_valid && !stall && state==IDLE.
  - The condition and target are evaluated combinationally in the accept cycle.
  - Only the registered result leaves the block.
- State machine, IDLE:
  - Accepted and taken: go to REDIRECT and latch the target into pc_target.
  - Accepted and not taken: stay in IDLE; pc_sel stays 0.
- State machine, REDIRECT:
  - pc_sel=1, flush=1, busy=1. Latency is 1 cycle from accept to pc_sel.
  - Held while stall=1.
  - On !stall: go to FLUSH if FLUSH_DEPTH>1, otherwise go to IDLE.
- State machine, FLUSH:
  - pc_sel=0, flush=1, busy=1.
  - The down-counter is loaded with FLUSH_DEPTH-1 on leaving REDIRECT and decrements only when !stall.
  - Go to IDLE when the counter reaches 1 and stall=0.
  - Total flush-high cycles with no stall = FLUSH_DEPTH.
- br_valid while busy=1 is a wrong-path instruction:
  - It is ignored and not counted.
  - A branch presented in the same cycle as the REDIRECT→IDLE or FLUSH→IDLE transition is also ignored.
- pc_target holds its value after the redirect, until the next taken branch.
- Simultaneous rst and br_valid: reset wins and nothing is accepted.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- With the macro defined:
  - br_count increments on every accepted branch; taken_count increments on every accepted taken branch.
  - Both saturate at 2^CNT_W-1 and never wrap.
  - Both update in the cycle after accept.
- Without the macro: br_count and taken_count are tied to 0, and no counter registers are built.

Test Plan:
- EQ taken: rs_a=rs_b=0x1234, br_pc=0x100, br_offset=0x20.
  - Next cycle: pc_sel=1, pc_target=0x120.
  - flush high for exactly 2 cycles; busy then drops to 0.
- Signed vs unsigned: rs_a=0xFFFFFFFF, rs_b=1.
  - br_op=011 (LT) → taken; br_op=101 (LTU) → not taken.
  - Not-taken case: pc_sel, flush and busy stay 0.
- Stall: stall=1 in the cycle after accept.
  - REDIRECT and pc_sel=1 hold for all 3 stalled cycles.
  - The flush count resumes only after stall drops; total unstalled flush cycles = 2.
- Wrap and squash:
  - br_pc=0xFFFFFFF0, br_offset=0x20 → pc_target=0x10.
  - br_valid pulses during FLUSH have no effect, and br_count does not increment for them.
- Reset mid-flush: assert rst during FLUSH.
  - Next edge: flush=0, busy=0, pc_sel=0.
  - A new branch the cycle after reset releases is accepted normally.
- BRANCH_STATS_EN: issue 5 branches, 3 of them taken → br_count=5, taken_count=3.
  - With CNT_W=2, issue 6 taken branches → both counters hold at 3.
